// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types, ROM word layout and note step table for the melody player
package melody_pkg;

    localparam int WORD_W     = 16;
    localparam int END_BIT    = 15;
    localparam int INSTRU_BIT = 14;
    localparam int NOTE_LSB   = 8;
    localparam int NOTE_W     = 6;
    localparam int DUR_LSB    = 0;
    localparam int DUR_W      = 8;
    localparam int STEP_W     = 16;
    localparam int NOTE_A4    = 22;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        NOTE,
        GAP
    } state_t;

    // round(f_Hz * 1.25): phase step for a 60000-wrap accumulator at 48 kHz.
    // Index 1..36 is C3..B5; index 0 and 37..63 are silent and play as rests.
    localparam logic [STEP_W-1:0] STEP_TABLE [64] = '{
        16'd0,
        16'd164,  16'd173,  16'd184,  16'd194,  16'd206,  16'd218,
        16'd231,  16'd245,  16'd260,  16'd275,  16'd291,  16'd309,
        16'd327,  16'd346,  16'd367,  16'd389,  16'd412,  16'd437,
        16'd462,  16'd490,  16'd519,  16'd550,  16'd583,  16'd617,
        16'd654,  16'd693,  16'd734,  16'd778,  16'd824,  16'd873,
        16'd925,  16'd980,  16'd1038, 16'd1100, 16'd1165, 16'd1235,
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
    };

    function automatic logic [STEP_W-1:0] note_step(input logic [NOTE_W-1:0] idx);
        return STEP_TABLE[idx];
    endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - synchronous-read melody ROM, contents supplied as a flat parameter image
module melody_rom
    import melody_pkg::*;
#(
    parameter int                              ADDR_W = 6,
    parameter logic [(2**ADDR_W)*WORD_W-1:0]   INIT   = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    // Entry i occupies INIT[i*WORD_W +: WORD_W]; one clock of read latency.
    always_ff @(posedge clk) begin
        data <= INIT[int'(addr) * WORD_W +: WORD_W];
    end

endmodule

// File: rtl/melody_player.sv
// rtl/melody_player.sv - steps through the melody ROM and drives the codec key-on, step and timbre inputs
module melody_player
    import melody_pkg::*;
#(
    parameter int                              TICK_DIV   = 1152000,
    parameter int                              GAP_CYCLES = 768,
    parameter int                              ADDR_W     = 6,
    parameter bit                              LOOP       = 1'b0,
    parameter logic [(2**ADDR_W)*WORD_W-1:0]   ROM_INIT   = '0
) (
    input  logic              iCLK_18_4,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic              iSTOP,
    output logic              oKEY_ON,
    output logic [STEP_W-1:0] oSTEP,
    output logic              oINSTRU,
    output logic              oBUSY,
    output logic [ADDR_W-1:0] oADDR
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr, addr_n;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_n;
    logic [DUR_W-1:0]   dur_cnt, dur_cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic               key_on, key_on_n;
    logic [STEP_W-1:0]  step, step_n;
    logic               instru, instru_n;
    logic               busy, busy_n;

    logic [WORD_W-1:0]  rom_word;
    logic               rom_end;
    logic               rom_instru;
    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;
    logic [STEP_W-1:0]  rom_step;

    melody_rom #(
        .ADDR_W (ADDR_W),
        .INIT   (ROM_INIT)
    ) u_rom (
        .clk  (iCLK_18_4),
        .addr (addr),
        .data (rom_word)
    );

    assign rom_end    = rom_word[END_BIT];
    assign rom_instru = rom_word[INSTRU_BIT];
    assign rom_note   = rom_word[NOTE_LSB +: NOTE_W];
    assign rom_dur    = rom_word[DUR_LSB +: DUR_W];
    assign rom_step   = note_step(rom_note);

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state    <= IDLE;
            addr     <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            key_on   <= 1'b0;
            step     <= '0;
            instru   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            tick_cnt <= tick_cnt_n;
            dur_cnt  <= dur_cnt_n;
            gap_cnt  <= gap_cnt_n;
            key_on   <= key_on_n;
            step     <= step_n;
            instru   <= instru_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        tick_cnt_n = tick_cnt;
        dur_cnt_n  = dur_cnt;
        gap_cnt_n  = gap_cnt;
        key_on_n   = key_on;
        step_n     = step;
        instru_n   = instru;

        if (iSTOP) begin
            state_n    = IDLE;
            addr_n     = '0;
            tick_cnt_n = '0;
            dur_cnt_n  = '0;
            gap_cnt_n  = '0;
            key_on_n   = 1'b0;
            step_n     = '0;
            instru_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iSTART) begin
                        state_n = FETCH;
                        addr_n  = '0;
                    end
                end
                FETCH: begin
                    state_n = DECODE;
                end
                DECODE: begin
                    if (rom_end) begin
                        if (LOOP) begin
                            state_n = FETCH;
                            addr_n  = '0;
                        end else begin
                            state_n  = IDLE;
                            addr_n   = '0;
                            step_n   = '0;
                            instru_n = 1'b0;
                        end
                    end else begin
                        state_n    = NOTE;
                        step_n     = rom_step;
                        instru_n   = rom_instru;
                        key_on_n   = (rom_step != '0);
                        dur_cnt_n  = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                        tick_cnt_n = '0;
                    end
                end
                NOTE: begin
                    // dur_cnt counts remaining ticks including the current one.
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        if (dur_cnt == DUR_W'(1)) begin
                            state_n   = GAP;
                            key_on_n  = 1'b0;
                            gap_cnt_n = '0;
                            dur_cnt_n = '0;
                        end else begin
                            dur_cnt_n = dur_cnt - DUR_W'(1);
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n   = FETCH;
                        gap_cnt_n = '0;
                        addr_n    = addr + ADDR_W'(1);
                    end else begin
                        gap_cnt_n = gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    assign oKEY_ON = key_on;
    assign oSTEP   = step;
    assign oINSTRU = instru;
    assign oBUSY   = busy;
    assign oADDR   = addr;

endmodule
